adc_delay_capture: RTL and testbench

ADC_DELAY_CAPTURE -- requirements
Module: adc_delay_capture

---
 rtl/adc_pkg.sv | 16 +
 rtl/delay_line.sv | 31 +++
 rtl/adc_delay_capture.sv | 120 ++++++++++++
 tb/tb_adc_delay_capture.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared FSM state type and default sizing for the ADC delay capture
package adc_pkg;

   localparam int DEF_DATA_W  = 14;
   localparam int DEF_DEPTH   = 100;
   localparam int DEF_PRETRIG = 20;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_ARMED = 3'd2,
      S_POST  = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

endpackage

// File: rtl/delay_line.sv
// rtl/delay_line.sv - DEPTH-tap shift register with shift enable, tap [0] is newest
module delay_line #(
   parameter int DATA_W = 14,
   parameter int DEPTH  = 100
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              shift_en_i,
   input  logic [DATA_W-1:0] din_i,
   output logic [DATA_W-1:0] taps_o [DEPTH]
);

   logic [DATA_W-1:0] taps_q [DEPTH];

   // Shift one sample in at [0] when enabled; hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            taps_q[i] <= '0;
         end
      end else if (shift_en_i) begin
         taps_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) begin
            taps_q[i] <= taps_q[i-1];
         end
      end
   end

   assign taps_o = taps_q;

endmodule

// File: rtl/adc_delay_capture.sv
// rtl/adc_delay_capture.sv - ADC delay line with threshold-triggered window capture
module adc_delay_capture
   import adc_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int PRETRIG    = DEF_PRETRIG,
   parameter int CONTINUOUS = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] ADC_IN,
   input  logic [DATA_W-1:0] threshold,
   input  logic              arm,
   input  logic              ack,
   output logic [DATA_W-1:0] DelayVec [DEPTH],
   output logic              valid,
   output logic [15:0]       trig_count
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   // Samples that must follow the trigger sample to place it at [DEPTH-PRETRIG-1].
   localparam int POST_LEN = DEPTH - PRETRIG - 1;

   state_t           state_q;
   logic [CNT_W-1:0] fill_cnt_q;
   logic [CNT_W-1:0] post_cnt_q;
   logic             valid_q;
   logic [15:0]      trig_count_q;
   logic             shift_en;
   logic             trig_hit;

   // Only a held window freezes the line; free-running mode never holds.
   assign shift_en = (CONTINUOUS != 0) || (state_q != S_HOLD);

   // Rising crossing: new sample at/above the level, previous sample below it.
   assign trig_hit = (ADC_IN >= threshold) && (DelayVec[0] < threshold);

   delay_line #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_delay_line (
      .clk        (clk),
      .rst_n      (rst_n),
      .shift_en_i (shift_en),
      .din_i      (ADC_IN),
      .taps_o     (DelayVec)
   );

   // Capture FSM with registered valid and trigger counter; parked in IDLE when free-running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         fill_cnt_q   <= '0;
         post_cnt_q   <= '0;
         valid_q      <= 1'b0;
         trig_count_q <= '0;
      end else if (CONTINUOUS == 0) begin
         case (state_q)
            S_IDLE: begin
               if (arm) begin
                  state_q    <= S_FILL;
                  fill_cnt_q <= '0;
               end
            end
            S_FILL: begin
               if (!arm) begin
                  state_q <= S_IDLE;
               end else if (fill_cnt_q == CNT_W'(PRETRIG - 1)) begin
                  state_q <= S_ARMED;
               end else begin
                  fill_cnt_q <= fill_cnt_q + 1'b1;
               end
            end
            S_ARMED: begin
               if (!arm) begin
                  state_q <= S_IDLE;
               end else if (trig_hit) begin
                  trig_count_q <= trig_count_q + 16'd1;
                  if (POST_LEN == 0) begin
                     state_q <= S_HOLD;
                     valid_q <= 1'b1;
                  end else begin
                     post_cnt_q <= CNT_W'(POST_LEN);
                     state_q    <= S_POST;
                  end
               end
            end
            S_POST: begin
               // Counter holds the samples still to shift; the last one lands as we enter HOLD.
               if (!arm) begin
                  state_q <= S_IDLE;
               end else if (post_cnt_q == CNT_W'(1)) begin
                  post_cnt_q <= '0;
                  state_q    <= S_HOLD;
                  valid_q    <= 1'b1;
               end else begin
                  post_cnt_q <= post_cnt_q - 1'b1;
               end
            end
            S_HOLD: begin
               if (ack) begin
                  valid_q <= 1'b0;
                  if (arm) begin
                     state_q    <= S_FILL;
                     fill_cnt_q <= '0;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign valid      = valid_q;
   assign trig_count = trig_count_q;

endmodule

// File: tb/tb_adc_delay_capture.sv
// tb/tb_adc_delay_capture.sv - directed self-checking bench for adc_delay_capture
module tb_adc_delay_capture;

   localparam int DW = 14;
   localparam int DP = 100;
   localparam int PT = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] adc = '0;
   logic [DW-1:0] thr = '0;
   logic          arm = 1'b0;
   logic          ack = 1'b0;

   logic [DW-1:0] dv_t [DP];
   logic          valid_t;
   logic [15:0]   tc_t;
   logic [DW-1:0] dv_c [DP];
   logic          valid_c;
   logic [15:0]   tc_c;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   adc_delay_capture #(.DATA_W(DW), .DEPTH(DP), .PRETRIG(PT), .CONTINUOUS(0)) u_trig (
      .clk(clk), .rst_n(rst_n), .ADC_IN(adc), .threshold(thr), .arm(arm), .ack(ack),
      .DelayVec(dv_t), .valid(valid_t), .trig_count(tc_t)
   );

   adc_delay_capture #(.DATA_W(DW), .DEPTH(DP), .PRETRIG(PT), .CONTINUOUS(1)) u_cont (
      .clk(clk), .rst_n(rst_n), .ADC_IN(adc), .threshold(thr), .arm(arm), .ack(ack),
      .DelayVec(dv_c), .valid(valid_c), .trig_count(tc_c)
   );

   task automatic push(input logic [DW-1:0] s);
      adc = s;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] post_val(input int k);
      case (k)
         1: return 14'd13843;
         2: return 14'd11721;
         3: return 14'd8000;
         4: return 14'd12500;
         default: return 14'(8100 + k);
      endcase
   endfunction

   task automatic test_reset();
      int nz;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nz = 0;
      for (int i = 0; i < DP; i++) if (dv_t[i] !== '0 || dv_c[i] !== '0) nz++;
      checks++; if (nz !== 0) begin failures++; $display("FAIL reset_delayvec nonzero=%0d exp=0", nz); end
      checks++; if (valid_t !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid_t); end
      checks++; if (tc_t !== 16'd0) begin failures++; $display("FAIL reset_trig_count got=%0d exp=0", tc_t); end
      checks++; if (valid_c !== 1'b0) begin failures++; $display("FAIL reset_valid_cont got=%0b exp=0", valid_c); end
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_continuous();
      push(14'd8054);
      push(14'd8062);
      push(14'd8051);
      checks++; if (dv_c[0] !== 14'd8051) begin failures++; $display("FAIL cont_dv0 got=%0d exp=8051", dv_c[0]); end
      checks++; if (dv_c[1] !== 14'd8062) begin failures++; $display("FAIL cont_dv1 got=%0d exp=8062", dv_c[1]); end
      checks++; if (dv_c[2] !== 14'd8054) begin failures++; $display("FAIL cont_dv2 got=%0d exp=8054", dv_c[2]); end
   endtask

   task automatic test_capture();
      thr = 14'd10000;
      arm = 1'b1;
      for (int i = 0; i <= PT; i++) push(14'(8050 + (i * 7) % 30));
      push(14'd11054);
      checks++; if (tc_t !== 16'd1) begin failures++; $display("FAIL cap_trig_count got=%0d exp=1", tc_t); end
      checks++; if (valid_t !== 1'b0) begin failures++; $display("FAIL cap_valid_early got=%0b exp=0", valid_t); end
      for (int k = 1; k <= 78; k++) push(post_val(k));
      checks++; if (tc_t !== 16'd1) begin failures++; $display("FAIL post_crossing_count got=%0d exp=1", tc_t); end
      checks++; if (valid_t !== 1'b0) begin failures++; $display("FAIL cap_valid_p78 got=%0b exp=0", valid_t); end
      push(post_val(79));
      checks++; if (valid_t !== 1'b1) begin failures++; $display("FAIL cap_valid_p79 got=%0b exp=1", valid_t); end
      checks++; if (dv_t[79] !== 14'd11054) begin failures++; $display("FAIL cap_dv79 got=%0d exp=11054", dv_t[79]); end
      checks++; if (dv_t[78] !== 14'd13843) begin failures++; $display("FAIL cap_dv78 got=%0d exp=13843", dv_t[78]); end
      checks++; if (dv_t[75] !== 14'd12500) begin failures++; $display("FAIL cap_dv75 got=%0d exp=12500", dv_t[75]); end
      checks++; if (dv_t[80] !== 14'(8050 + (20 * 7) % 30)) begin failures++; $display("FAIL cap_dv80 got=%0d exp=%0d", dv_t[80], 8050 + (20 * 7) % 30); end
      checks++; if (dv_t[99] !== 14'(8050 + 7)) begin failures++; $display("FAIL cap_dv99 got=%0d exp=8057", dv_t[99]); end
      checks++; if (dv_t[0] !== 14'd8179) begin failures++; $display("FAIL cap_dv0 got=%0d exp=8179", dv_t[0]); end
      checks++; if (valid_c !== 1'b0 || tc_c !== 16'd0) begin failures++; $display("FAIL cont_ignores_trig valid=%0b count=%0d exp=0/0", valid_c, tc_c); end
   endtask

   task automatic test_hold();
      arm = 1'b0;
      push(14'd12000);
      push(14'd8000);
      push(14'd12000);
      checks++; if (valid_t !== 1'b1) begin failures++; $display("FAIL hold_valid got=%0b exp=1", valid_t); end
      checks++; if (dv_t[0] !== 14'd8179) begin failures++; $display("FAIL hold_frozen got=%0d exp=8179", dv_t[0]); end
      checks++; if (tc_t !== 16'd1) begin failures++; $display("FAIL hold_count got=%0d exp=1", tc_t); end
      arm = 1'b1;
   endtask

   task automatic test_ack_refill();
      ack = 1'b1;
      push(14'd9000);
      ack = 1'b0;
      checks++; if (valid_t !== 1'b0) begin failures++; $display("FAIL ack_valid got=%0b exp=0", valid_t); end
      checks++; if (dv_t[0] !== 14'd8179) begin failures++; $display("FAIL ack_no_shift got=%0d exp=8179", dv_t[0]); end
      for (int i = 1; i <= 20; i++) push(i == 19 ? 14'd8000 : (i == 20 ? 14'd12000 : 14'(8200 + i)));
      checks++; if (tc_t !== 16'd1) begin failures++; $display("FAIL fill_cross_ignored got=%0d exp=1", tc_t); end
      checks++; if (dv_t[0] !== 14'd12000) begin failures++; $display("FAIL fill_shifting got=%0d exp=12000", dv_t[0]); end
      push(14'd8000);
      checks++; if (tc_t !== 16'd1) begin failures++; $display("FAIL armed_below got=%0d exp=1", tc_t); end
      push(14'd12000);
      checks++; if (tc_t !== 16'd2) begin failures++; $display("FAIL rearm_trig got=%0d exp=2", tc_t); end
   endtask

   task automatic test_arm_drop();
      int seen;
      push(14'd8300);
      push(14'd8301);
      arm = 1'b0;
      seen = 0;
      for (int i = 0; i < 90; i++) begin
         push(14'(8302 + i));
         if (valid_t !== 1'b0) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL drop_valid_seen got=%0d exp=0", seen); end
      checks++; if (tc_t !== 16'd2) begin failures++; $display("FAIL drop_count got=%0d exp=2", tc_t); end
   endtask

   task automatic test_early_cross_and_equal();
      arm = 1'b1;
      push(14'd8050);
      for (int i = 1; i <= 20; i++) push(i == 10 ? 14'd12000 : 14'd8000);
      checks++; if (tc_t !== 16'd2) begin failures++; $display("FAIL early_cross got=%0d exp=2", tc_t); end
      push(14'd10000);
      checks++; if (tc_t !== 16'd3) begin failures++; $display("FAIL equal_trig got=%0d exp=3", tc_t); end
      for (int k = 1; k <= 79; k++) push(14'd8400);
      checks++; if (valid_t !== 1'b1 || dv_t[79] !== 14'd10000) begin failures++; $display("FAIL equal_window valid=%0b dv79=%0d exp=1/10000", valid_t, dv_t[79]); end
   endtask

   task automatic test_reset_in_hold();
      int nz;
      #2;
      rst_n = 1'b0;
      #1;
      nz = 0;
      for (int i = 0; i < DP; i++) if (dv_t[i] !== '0) nz++;
      checks++; if (nz !== 0) begin failures++; $display("FAIL hold_reset_dv nonzero=%0d exp=0", nz); end
      checks++; if (valid_t !== 1'b0) begin failures++; $display("FAIL hold_reset_valid got=%0b exp=0", valid_t); end
      checks++; if (tc_t !== 16'd0) begin failures++; $display("FAIL hold_reset_count got=%0d exp=0", tc_t); end
      #1;
      rst_n = 1'b1;
      arm = 1'b0;
      push(14'd5555);
      checks++; if (dv_t[0] !== 14'd5555 || dv_t[1] !== 14'd0) begin failures++; $display("FAIL resume_idle dv0=%0d dv1=%0d exp=5555/0", dv_t[0], dv_t[1]); end
      checks++; if (valid_t !== 1'b0) begin failures++; $display("FAIL resume_valid got=%0b exp=0", valid_t); end
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_capture();
      test_hold();
      test_ack_refill();
      test_arm_drop();
      test_early_cross_and_equal();
      test_reset_in_hold();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
